// File: rtl/tdm_link_pkg.sv
// Shared constants and types for the four-channel dispatch link receive path.
package tdm_link_pkg;

  localparam logic [7:0]  SYNC_WORD_DEF      = 8'hA5;
  localparam int unsigned SLOT_W             = 4;
  localparam int unsigned NUM_SLOTS          = 4;
  localparam int unsigned SLOT_BITS          = SLOT_W + 1;
  localparam int unsigned FRAME_PAYLOAD_BITS = NUM_SLOTS * SLOT_BITS;
  localparam int unsigned SYNC_BITS          = 8;

  localparam int unsigned LOCAL_LIB = 0;
  localparam int unsigned FIRE_DEPT = 1;
  localparam int unsigned SCHOOL    = 2;
  localparam int unsigned RIB_SHACK = 3;

  typedef enum logic [1:0] {
    HUNT,
    RECV,
    VERIFY
  } rx_state_e;

endpackage

// File: rtl/slot_parity_chk.sv
// Even-parity check of one {d3,d2,d1,d0,p} slot.
module slot_parity_chk
  import tdm_link_pkg::*;
(
  input  logic [SLOT_BITS-1:0] slot_i,
  output logic                 ok_o
);

  assign ok_o = ~(^slot_i);

endmodule

// File: rtl/tdm_deframer_rx.sv
// Serial TDM deframer: sync hunt, flywheel lock tracking and per-slot
// parity-checked dispatch into four destination registers.
module tdm_deframer_rx
  import tdm_link_pkg::*;
#(
  parameter logic [7:0]  SYNC_WORD  = SYNC_WORD_DEF,
  parameter int unsigned MISS_LIMIT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bit_en,
  input  logic                 sdata,
  input  logic                 enable,
  input  logic [NUM_SLOTS-1:0] dest_mask,
  output logic [SLOT_W-1:0]    local_lib,
  output logic [SLOT_W-1:0]    fire_department,
  output logic [SLOT_W-1:0]    school,
  output logic [SLOT_W-1:0]    rib_shack,
  output logic                 locked,
  output logic                 frame_valid,
  output logic [NUM_SLOTS-1:0] parity_err
);

  rx_state_e state_q, state_d;

  // Shifters keep one bit less than their width; the incoming bit completes the word.
  logic [SYNC_BITS-2:0]          shift_q, shift_d;
  logic [FRAME_PAYLOAD_BITS-2:0] pay_q, pay_d;
  logic [4:0]                    cnt_q, cnt_d;
  logic [2:0]                    miss_q, miss_d;
  logic                          conf_q, conf_d;
  logic                          locked_q, locked_d;
  logic                          fv_q, fv_d;
  logic [NUM_SLOTS-1:0]          perr_q, perr_d;
  logic [SLOT_W-1:0]             slot_q [NUM_SLOTS];
  logic [SLOT_W-1:0]             slot_d [NUM_SLOTS];

  logic [SYNC_BITS-1:0]          shift_nx;
  logic [FRAME_PAYLOAD_BITS-1:0] pay_nx;
  logic [2:0]                    miss_inc;
  logic [SLOT_BITS-1:0]          slot_bits [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]          slot_ok;

  assign shift_nx = {shift_q, sdata};
  assign pay_nx   = {pay_q, sdata};
  assign miss_inc = miss_q + 3'd1;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    assign slot_bits[g] = pay_nx[FRAME_PAYLOAD_BITS-1-g*SLOT_BITS -: SLOT_BITS];

    slot_parity_chk u_chk (
      .slot_i (slot_bits[g]),
      .ok_o   (slot_ok[g])
    );
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    pay_d    = pay_q;
    cnt_d    = cnt_q;
    miss_d   = miss_q;
    conf_d   = conf_q;
    locked_d = locked_q;
    slot_d   = slot_q;
    fv_d     = 1'b0;
    perr_d   = '0;

    if (bit_en) begin
      case (state_q)
        HUNT: begin
          shift_d = shift_nx[SYNC_BITS-2:0];
          if (shift_nx == SYNC_WORD) begin
            state_d  = RECV;
            locked_d = 1'b1;
            conf_d   = 1'b1;
            miss_d   = '0;
            cnt_d    = '0;
          end
        end

        RECV: begin
          pay_d = pay_nx[FRAME_PAYLOAD_BITS-2:0];
          if (cnt_q == 5'(FRAME_PAYLOAD_BITS - 1)) begin
            cnt_d   = '0;
            state_d = VERIFY;
            if (conf_q) begin
              fv_d = 1'b1;
              for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
                if (!slot_ok[k]) begin
                  perr_d[k] = 1'b1;
                end else if (enable && dest_mask[k]) begin
                  slot_d[k] = slot_bits[k][SLOT_BITS-1:1];
                end
              end
            end
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end

        VERIFY: begin
          shift_d = shift_nx[SYNC_BITS-2:0];
          if (cnt_q == 5'(SYNC_BITS - 1)) begin
            cnt_d = '0;
            if (shift_nx == SYNC_WORD) begin
              state_d = RECV;
              conf_d  = 1'b1;
              miss_d  = '0;
            end else if (miss_inc == 3'(MISS_LIMIT)) begin
              state_d  = HUNT;
              locked_d = 1'b0;
              conf_d   = 1'b0;
              miss_d   = miss_inc;
              shift_d  = '0;
            end else begin
              state_d = RECV;
              conf_d  = 1'b0;
              miss_d  = miss_inc;
            end
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end

        default: begin
          state_d  = HUNT;
          locked_d = 1'b0;
          shift_d  = '0;
          cnt_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      shift_q  <= '0;
      pay_q    <= '0;
      cnt_q    <= '0;
      miss_q   <= '0;
      conf_q   <= 1'b0;
      locked_q <= 1'b0;
      fv_q     <= 1'b0;
      perr_q   <= '0;
      slot_q   <= '{default: '0};
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      pay_q    <= pay_d;
      cnt_q    <= cnt_d;
      miss_q   <= miss_d;
      conf_q   <= conf_d;
      locked_q <= locked_d;
      fv_q     <= fv_d;
      perr_q   <= perr_d;
      slot_q   <= slot_d;
    end
  end

  assign local_lib       = slot_q[LOCAL_LIB];
  assign fire_department = slot_q[FIRE_DEPT];
  assign school          = slot_q[SCHOOL];
  assign rib_shack       = slot_q[RIB_SHACK];
  assign locked          = locked_q;
  assign frame_valid     = fv_q;
  assign parity_err      = perr_q;

endmodule
